// File: rtl/enigma_pkg.sv
// Shared constants, parser state type and the set-2 make-code table for the
// keyboard-to-rotor letter path.
package enigma_pkg;

    localparam int NUM_LETTERS = 26;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } parse_state_e;

    // Entry i is the make code of letter i (A = 0).
    localparam logic [7:0] SCAN_TABLE [NUM_LETTERS] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

endpackage

// File: rtl/ps2_letter_strobe_if.sv
// Byte handshake between the PS/2 receiver (master) and the letter parser (slave).
interface ps2_letter_strobe_if;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       read;

    modport master (output scan_code, output scan_ready, input read);
    modport slave  (input scan_code, input scan_ready, output read);
endinterface

// File: rtl/scan_to_index.sv
// Combinational lookup of a set-2 make code into a letter index 0..25.
module scan_to_index
    import enigma_pkg::*;
(
    input  logic [7:0] scan_code,
    output logic [4:0] idx,
    output logic       is_letter
);

    always_comb begin
        idx       = '0;
        is_letter = 1'b0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (scan_code == SCAN_TABLE[i]) begin
                idx       = 5'(i);
                is_letter = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_letter_strobe.sv
// Parses PS/2 make/break/extended byte streams into once-per-press letter
// events: a rotor step pulse followed one cycle later by the one-hot letter.
module ps2_letter_strobe
    import enigma_pkg::*;
#(
    parameter bit REPEAT_OK = 1'b0
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    ps2_letter_strobe_if.slave     kb,
    input  logic                   clear,
    output logic                   step,
    output logic [NUM_LETTERS-1:0] letter,
    output logic [4:0]             letter_index,
    output logic                   letter_valid,
    output logic                   key_held,
    output logic [15:0]            letter_count
);

    parse_state_e           state_q, state_d;
    logic                   read_q, read_d;
    logic                   step_q, step_d;
    logic [4:0]             pend_idx_q, pend_idx_d;
    logic [7:0]             held_code_q, held_code_d;
    logic                   key_held_q, key_held_d;
    logic [NUM_LETTERS-1:0] letter_q, letter_d;
    logic [4:0]             letter_index_q, letter_index_d;
    logic                   letter_valid_q, letter_valid_d;
    logic [15:0]            letter_count_q, letter_count_d;

    logic [4:0] scan_idx;
    logic       scan_is_letter;
    logic       consume;
    logic       is_repeat;

    scan_to_index u_scan_to_index (
        .scan_code (kb.scan_code),
        .idx       (scan_idx),
        .is_letter (scan_is_letter)
    );

    // read_q high means the current byte was taken last cycle and may still be on the bus.
    assign consume   = kb.scan_ready && !read_q;
    assign is_repeat = key_held_q && (kb.scan_code == held_code_q) && !REPEAT_OK;

    always_comb begin
        state_d        = state_q;
        read_d         = consume;
        step_d         = 1'b0;
        pend_idx_d     = pend_idx_q;
        held_code_d    = held_code_q;
        key_held_d     = key_held_q;
        letter_d       = letter_q;
        letter_index_d = letter_index_q;
        letter_valid_d = 1'b0;
        letter_count_d = letter_count_q;

        if (consume) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (kb.scan_code == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (kb.scan_code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (scan_is_letter && !is_repeat) begin
                        step_d      = 1'b1;
                        pend_idx_d  = scan_idx;
                        held_code_d = kb.scan_code;
                        key_held_d  = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (kb.scan_code != SC_BREAK) begin
                        state_d = ST_IDLE;
                        if (kb.scan_code == held_code_q) key_held_d = 1'b0;
                    end
                end
                ST_EXT: begin
                    if (kb.scan_code == SC_BREAK)   state_d = ST_EXT_BRK;
                    else if (kb.scan_code != SC_EXT) state_d = ST_IDLE;
                end
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end

        // The step pulse doubles as the pending-update flag; a letter update beats clear.
        if (step_q) begin
            letter_d       = {{(NUM_LETTERS-1){1'b0}}, 1'b1} << pend_idx_q;
            letter_index_d = pend_idx_q;
            letter_valid_d = 1'b1;
            letter_count_d = letter_count_q + 16'd1;
        end else if (clear) begin
            letter_d       = '0;
            letter_index_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            read_q         <= 1'b0;
            step_q         <= 1'b0;
            pend_idx_q     <= '0;
            held_code_q    <= '0;
            key_held_q     <= 1'b0;
            letter_q       <= '0;
            letter_index_q <= '0;
            letter_valid_q <= 1'b0;
            letter_count_q <= '0;
        end else begin
            state_q        <= state_d;
            read_q         <= read_d;
            step_q         <= step_d;
            pend_idx_q     <= pend_idx_d;
            held_code_q    <= held_code_d;
            key_held_q     <= key_held_d;
            letter_q       <= letter_d;
            letter_index_q <= letter_index_d;
            letter_valid_q <= letter_valid_d;
            letter_count_q <= letter_count_d;
        end
    end

    assign kb.read      = read_q;
    assign step         = step_q;
    assign letter       = letter_q;
    assign letter_index = letter_index_q;
    assign letter_valid = letter_valid_q;
    assign key_held     = key_held_q;
    assign letter_count = letter_count_q;

endmodule

// File: tb/tb_ps2_letter_strobe.sv
// Drives one byte stream into two parsers (repeats suppressed / allowed) and
// compares both against a keypress-level reference model.
module tb_ps2_letter_strobe;

    logic        CLOCK_50;
    logic        reset;
    logic        clear;
    logic [7:0]  scan_code;
    logic        scan_ready;

    logic        step_o         [2];
    logic [25:0] letter_o       [2];
    logic [4:0]  letter_index_o [2];
    logic        letter_valid_o [2];
    logic        key_held_o     [2];
    logic [15:0] letter_count_o [2];
    logic        read_o         [2];

    ps2_letter_strobe_if kb0 ();
    ps2_letter_strobe_if kb1 ();

    assign kb0.scan_code  = scan_code;
    assign kb0.scan_ready = scan_ready;
    assign kb1.scan_code  = scan_code;
    assign kb1.scan_ready = scan_ready;
    assign read_o[0]      = kb0.read;
    assign read_o[1]      = kb1.read;

    ps2_letter_strobe #(.REPEAT_OK(1'b0)) dut0 (
        .CLOCK_50 (CLOCK_50), .reset (reset), .kb (kb0.slave), .clear (clear),
        .step (step_o[0]), .letter (letter_o[0]), .letter_index (letter_index_o[0]),
        .letter_valid (letter_valid_o[0]), .key_held (key_held_o[0]),
        .letter_count (letter_count_o[0])
    );

    ps2_letter_strobe #(.REPEAT_OK(1'b1)) dut1 (
        .CLOCK_50 (CLOCK_50), .reset (reset), .kb (kb1.slave), .clear (clear),
        .step (step_o[1]), .letter (letter_o[1]), .letter_index (letter_index_o[1]),
        .letter_valid (letter_valid_o[1]), .key_held (key_held_o[1]),
        .letter_count (letter_count_o[1])
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference model: prefix 0 = none, 1 = after F0, 2 = after E0, 3 = after E0 F0.
    logic [7:0] codes [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    int          m_pre    [2];
    bit          m_held   [2];
    logic [7:0]  m_code   [2];
    logic [25:0] m_letter [2];
    int          m_idx    [2];
    logic [15:0] m_cnt    [2];

    function automatic int letter_of(input logic [7:0] b);
        for (int i = 0; i < 26; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_pre[r] = 0; m_held[r] = 0; m_code[r] = 8'h00;
            m_letter[r] = '0; m_idx[r] = 0; m_cnt[r] = '0;
        end
    endtask

    task automatic model_byte(input int r, input logic [7:0] b, output bit ev, output int ix);
        ev = 0;
        ix = letter_of(b);
        case (m_pre[r])
            0: begin
                if (b == 8'hF0) m_pre[r] = 1;
                else if (b == 8'hE0) m_pre[r] = 2;
                else if (ix >= 0 && !(m_held[r] && m_code[r] == b && r == 0)) begin
                    ev = 1; m_held[r] = 1; m_code[r] = b;
                end
            end
            1: if (b != 8'hF0) begin
                m_pre[r] = 0;
                if (b == m_code[r]) m_held[r] = 0;
            end
            2: if (b == 8'hF0) m_pre[r] = 3; else if (b != 8'hE0) m_pre[r] = 0;
            default: m_pre[r] = 0;
        endcase
    endtask

    task automatic check_letter(input int r, input bit exp_valid);
        chk($sformatf("r%0d letter_valid", r), 32'(letter_valid_o[r]), 32'(exp_valid));
        chk($sformatf("r%0d letter", r), 32'(letter_o[r]), 32'(m_letter[r]));
        chk($sformatf("r%0d letter_index", r), 32'(letter_index_o[r]), 32'(m_idx[r]));
        chk($sformatf("r%0d letter_count", r), 32'(letter_count_o[r]), 32'(m_cnt[r]));
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1; scan_ready = 1'b0; clear = 1'b0;
        @(posedge CLOCK_50); #1;
        model_reset();
        for (int r = 0; r < 2; r++) begin
            chk($sformatf("r%0d rst read", r), 32'(read_o[r]), 32'd0);
            chk($sformatf("r%0d rst step", r), 32'(step_o[r]), 32'd0);
            chk($sformatf("r%0d rst key_held", r), 32'(key_held_o[r]), 32'd0);
            check_letter(r, 1'b0);
        end
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit clr_upd);
        bit ev [2];
        int ix [2];
        bit e;
        int x;
        @(negedge CLOCK_50);
        scan_code = b; scan_ready = 1'b1; clear = 1'b0;
        @(posedge CLOCK_50); #1;
        for (int r = 0; r < 2; r++) begin
            model_byte(r, b, e, x);
            ev[r] = e; ix[r] = x;
            chk($sformatf("r%0d read %h", r, b), 32'(read_o[r]), 32'd1);
            chk($sformatf("r%0d step %h", r, b), 32'(step_o[r]), 32'(ev[r]));
            chk($sformatf("r%0d key_held %h", r, b), 32'(key_held_o[r]), 32'(m_held[r]));
        end
        @(negedge CLOCK_50);
        scan_ready = 1'b0; clear = clr_upd;
        @(posedge CLOCK_50); #1;
        for (int r = 0; r < 2; r++) begin
            if (ev[r]) begin
                m_letter[r] = 26'd1 << ix[r];
                m_idx[r]    = ix[r];
                m_cnt[r]    = m_cnt[r] + 16'd1;
            end else if (clr_upd) begin
                m_letter[r] = '0;
                m_idx[r]    = 0;
            end
            chk($sformatf("r%0d read drop", r), 32'(read_o[r]), 32'd0);
            chk($sformatf("r%0d step drop", r), 32'(step_o[r]), 32'd0);
            check_letter(r, ev[r]);
        end
    endtask

    // mode 0: no clear, 1: random clear, 2: clear every cycle
    task automatic idle_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            clear = (mode == 2) || (mode == 1 && $urandom_range(0, 3) == 0);
            @(posedge CLOCK_50); #1;
            for (int r = 0; r < 2; r++) begin
                if (clear) begin
                    m_letter[r] = '0;
                    m_idx[r]    = 0;
                end
                chk($sformatf("r%0d idle step", r), 32'(step_o[r]), 32'd0);
                check_letter(r, 1'b0);
            end
        end
        @(negedge CLOCK_50);
        clear = 1'b0;
    endtask

    logic [7:0] last_code;
    logic [7:0] misc [4];

    initial begin
        reset = 1'b1; clear = 1'b0; scan_code = 8'h00; scan_ready = 1'b0;
        misc[0] = 8'hAA; misc[1] = 8'hFA; misc[2] = 8'h5A; misc[3] = 8'h00;
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        do_reset();

        // basic make / break
        send(8'h1C, 0);
        chk("A letter", 32'(letter_o[0]), 32'h1);
        chk("A count", 32'(letter_count_o[0]), 32'd1);
        send(8'hF0, 0);
        send(8'h1C, 0);
        chk("A released", 32'(key_held_o[0]), 32'd0);
        idle_cycles(2, 0);

        // typematic repeat
        do_reset();
        send(8'h24, 0); send(8'h24, 0); send(8'h24, 0); send(8'hF0, 0); send(8'h24, 0);
        chk("repeat count suppressed", 32'(letter_count_o[0]), 32'd1);
        chk("repeat count allowed", 32'(letter_count_o[1]), 32'd3);
        chk("repeat index", 32'(letter_index_o[0]), 32'd4);

        // rollover
        do_reset();
        send(8'h1C, 0); send(8'h32, 0); send(8'hF0, 0); send(8'h1C, 0);
        chk("rollover still held", 32'(key_held_o[0]), 32'd1);
        send(8'hF0, 0); send(8'h32, 0);
        chk("rollover released", 32'(key_held_o[0]), 32'd0);
        chk("rollover last B", 32'(letter_o[0]), 32'h2);

        // extended and non-letter bytes
        send(8'h1C, 0);
        send(8'hE0, 0); send(8'h1C, 0);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h1C, 0);
        send(8'hAA, 0); send(8'hFA, 0); send(8'h5A, 0);
        chk("ext letter kept", 32'(letter_o[0]), 32'h1);
        send(8'hF0, 0); send(8'h1C, 0);
        chk("ext back in idle", 32'(key_held_o[0]), 32'd0);

        // reset after F0 parses next byte as a make
        do_reset();
        send(8'hF0, 0);
        do_reset();
        send(8'h1A, 0);
        chk("Z letter", 32'(letter_o[0]), 32'h2000000);
        chk("Z index", 32'(letter_index_o[0]), 32'd25);

        // reset lands on the pending update cycle
        do_reset();
        @(negedge CLOCK_50);
        scan_code = 8'h21; scan_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        chk("pre-cancel step", 32'(step_o[0]), 32'd1);
        @(negedge CLOCK_50);
        scan_ready = 1'b0; reset = 1'b1;
        @(posedge CLOCK_50); #1;
        model_reset();
        chk("cancel valid", 32'(letter_valid_o[0]), 32'd0);
        chk("cancel letter", 32'(letter_o[0]), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;

        // clear against the update cycle, then on its own
        send(8'h15, 1);
        chk("clear loses to update", 32'(letter_o[0]), 32'h10000);
        idle_cycles(1, 2);
        chk("clear zeroes", 32'(letter_o[0]), 32'd0);
        chk("clear keeps count", 32'(letter_count_o[0]), 32'd1);

        // randomized stream
        do_reset();
        last_code = 8'h1C;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                b = codes[$urandom_range(0, 7)];
                last_code = b;
            end else if (sel == 4 || sel == 9) b = last_code;
            else if (sel <= 6) b = 8'hF0;
            else if (sel == 7) b = 8'hE0;
            else b = misc[$urandom_range(0, 3)];
            send(b, 1'($urandom_range(0, 3) == 0));
            idle_cycles($urandom_range(0, 2), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_letter_strobe.md
# ps2_letter_strobe

Converts raw PS/2 set-2 scan bytes from the keyboard receiver into clean, once-per-keypress letter events for the rotor stage. It parses make, break (`F0`) and extended (`E0`) sequences and suppresses typematic auto-repeat. For each new letter press it issues a one-cycle rotor step pulse, then presents the letter one-hot on the next cycle, so the rotors have already advanced when the letter is enciphered.

## Interface
- `REPEAT_OK`, 0: 1 = typematic repeats of a held letter produce events; 0 = suppressed.
- `CLOCK_50` in 1: sole clock, all logic on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state and outputs.
- `scan_code` in 8: byte from the keyboard receiver; valid while `scan_ready`=1.
- `scan_ready` in 1: level, high while an unread byte is pending.
- `read` out 1: one-cycle acknowledge that the pending byte was consumed.
- `clear` in 1: zeroes `letter` without disturbing parser state.
- `step` out 1: one-cycle pulse, rotor advance request.
- `letter` out 26: registered one-hot of the last accepted letter (bit 0 = A).
- `letter_index` out 5: binary index 0–25 of `letter`.
- `letter_valid` out 1: one-cycle pulse, `letter`/`letter_index` just updated.
- `key_held` out 1: a letter make has been seen without its break.
- `letter_count` out 16: accepted-letter counter, wraps at 0xFFFF→0.

## Operation
- Byte consume: when `scan_ready`=1 and `read` was low last cycle. `read`=1 on the following cycle. A byte is never consumed twice.
- FSM states: IDLE, BRK (after `F0`), EXT (after `E0`), EXT_BRK (after `E0 F0`). Reset → IDLE.
- IDLE: `F0`→BRK; `E0`→EXT; letter make code → candidate; other bytes (`AA`, `FA`, `EE`, `00`, `FF`, non-letters) are ignored and the state stays IDLE.
- BRK: `F0` stays BRK. Any other byte → IDLE. If that byte equals `held_code`, `key_held` clears; otherwise no effect.
- EXT: `F0`→EXT_BRK, `E0` stays EXT, any other byte → IDLE, no event.
- EXT_BRK: any byte → IDLE, no event. Extended keys never produce letters.
- Candidate handling:
  - Equal to `held_code` with `key_held`=1 and `REPEAT_OK`=0 → dropped.
  - Otherwise accepted. `held_code` ← byte and `key_held`=1. This covers rollover, where a new key is pressed while another is held.
- Accepted letter: `step` pulse, then one cycle later `letter`, `letter_index`, `letter_valid` and `letter_count`+1 all update together.
- `clear`=1 zeroes `letter` and `letter_index`. If a letter update lands in the same cycle, the update wins.
- Mapping (set-2 make → index): A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.

## Timing
- Byte present at cycle N (consumed) → `read` at N+1 → `step` at N+1 → `letter_valid` and new `letter` at N+2.
- Back-to-back bytes: the next byte is consumed no earlier than N+2, so the minimum spacing is 2 cycles.
- Reset values: `read`, `step`, `letter_valid`, `key_held` = 0; `letter` = 26'b0; `letter_index` = 0; `letter_count` = 0; `held_code` = 0; FSM = IDLE.
- Reset mid-sequence (e.g. after `F0`): the parser returns to IDLE, and the next byte is parsed as a fresh make. A pending N+2 letter update is cancelled.
- `letter` is stable between `letter_valid` pulses except when `clear` is asserted.

## Structure
- Shared package `enigma_pkg`:
  - constants `SC_BREAK` = 8'hF0 and `SC_EXT` = 8'hE0;
  - FSM state enum;
  - the 26-entry scan→index table;
  - `NUM_LETTERS` = 26.
- One combinational sub-module, `scan_to_index`: takes `scan_code` and produces `idx[4:0]` plus `is_letter`.
- One-hot expansion is `1 << idx` inside the block. The FSM, handshake and counter live in `ps2_letter_strobe`.

## Test plan
- Reset, then bytes `1C`, `F0`, `1C` → `step` at N+1, `letter_valid` at N+2 with `letter`=26'h1, `letter_index`=0 and `letter_count`=1; after the break, `key_held`=0.
- `REPEAT_OK`=0, bytes `24 24 24 F0 24` → exactly one event (index 4), `letter_count`=1. With `REPEAT_OK`=1 → three events, `letter_count`=3.
- Rollover `1C 32 F0 1C F0 32` → events A then B, and `key_held` clears only after `F0 32`.
- Extended `E0 1C`, `E0 F0 1C`, plus non-letters `AA FA 5A` → no `step`, no `letter_valid`; `letter` unchanged; FSM back in IDLE.
- `reset` asserted after `F0`, then `1A` → event Z (`letter` bit 25, `letter_index`=25), not treated as a break.
- `clear` asserted in the same cycle as the N+2 update for `15` → `letter` = bit 16 (Q). `clear` on the next cycle → `letter`=0, with `letter_count` unchanged.
